imem_loader: RTL

- Writer side of the instruction-memory interface. The core only reads instruction memory; this block fills it.
- Accepts a stream of 32-bit program words over a valid/ready handshake and writes them to consecutive instruction-memory word addresses.
- Verifies an additive checksum, then releases the core from reset.
- Sits beside the instruction memory in the processor top level and drives its write port plus the core's reset.

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader_if.sv | 20 ++
 rtl/imem_loader_checksum.sv | 41 ++++
 rtl/imem_loader.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
//   Shared types and constants for the instruction-memory loader.
//   state_t      : loader FSM state encoding
//   DATA_WIDTH_DEF : default program word width
package imem_loader_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    RUN   = 3'd3,
    ERR   = 3'd4
  } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Valid/ready stream carrying program words and the trailing checksum.
//   in_valid : source has a word on in_data
//   in_data  : program word or checksum word
//   in_last  : marks the final program word (not the checksum)
//   in_ready : loader accepts a word this cycle
//   master   : source side, slave : loader side
import imem_loader_pkg::*;

interface imem_loader_if #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  in_ready;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/imem_loader_checksum.sv
// loader_checksum
//   Clearable modulo-2^DATA_WIDTH additive accumulator with equality compare.
//   clk, reset : system clock, async active-low reset
//   i_clear    : zero the accumulator (wins over i_en)
//   i_en       : add i_data to the accumulator
//   i_data     : word to accumulate
//   i_cmp      : value compared against the current accumulator
//   o_sum      : current accumulator
//   o_match    : o_sum == i_cmp
import imem_loader_pkg::*;

module loader_checksum #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_clear,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [DATA_WIDTH-1:0] i_cmp,
  output logic [DATA_WIDTH-1:0] o_sum,
  output logic                  o_match
);

  logic [DATA_WIDTH-1:0] r_acc;

  // Carry out of the top bit is dropped on purpose: the sum is modular.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + i_data;
    end
  end

  assign o_sum   = r_acc;
  assign o_match = (r_acc == i_cmp);

endmodule

// File: rtl/imem_loader.sv
// imem_loader
//   Fills instruction memory from a word stream, verifies an additive
//   checksum and then releases the core from reset.
//   clk, reset     : system clock, async active-low reset
//   i_start        : one-cycle request to begin a (re)load
//   s_in           : program word stream (slave side)
//   o_imem_we      : instruction-memory write enable
//   o_imem_addr    : instruction-memory word address
//   o_imem_wdata   : instruction-memory write data
//   o_core_reset   : active-high core reset, held unless running
//   o_busy         : loading or checking
//   o_done         : program loaded and verified, core running
//   o_error        : overflow or checksum mismatch
//   o_word_count   : program words written in the current load
//
//   state | meaning
//   IDLE  | after reset, waiting for start
//   LOAD  | accepting program words, writing memory
//   CHECK | waiting for the checksum word
//   RUN   | checksum good, core released
//   ERR   | overflow or bad checksum, core held
import imem_loader_pkg::*;

module imem_loader #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  imem_loader_if.slave          s_in,
  output logic                  o_imem_we,
  output logic [ADDR_WIDTH-1:0] o_imem_addr,
  output logic [DATA_WIDTH-1:0] o_imem_wdata,
  output logic                  o_core_reset,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [ADDR_WIDTH:0]   o_word_count
);

  // word_count value meaning "memory full"
  localparam logic [ADDR_WIDTH:0] C_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH:0]   r_word_count;
  logic                  r_imem_we;
  logic [ADDR_WIDTH-1:0] r_imem_addr;
  logic [DATA_WIDTH-1:0] r_imem_wdata;
  logic                  w_ready;
  logic                  w_xfer;
  logic                  w_clear;
  logic                  w_wr;
  logic                  w_match;
  logic [DATA_WIDTH-1:0] w_sum;

  assign w_ready = (r_state == LOAD) || (r_state == CHECK);
  assign w_xfer  = s_in.in_valid && w_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_wr        = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nxt = LOAD;
          w_clear     = 1'b1;
        end
      end
      LOAD: begin
        if (w_xfer) begin
          // A word arriving with memory already full is dropped, not written.
          if (r_word_count == C_FULL) begin
            w_state_nxt = ERR;
          end else begin
            w_wr = 1'b1;
            if (s_in.in_last) begin
              w_state_nxt = CHECK;
            end
          end
        end
      end
      CHECK: begin
        if (w_xfer) begin
          w_state_nxt = w_match ? RUN : ERR;
        end
      end
      RUN, ERR: begin
        if (i_start) begin
          w_state_nxt = LOAD;
          w_clear     = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_word_count <= '0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
    end else begin
      r_imem_we <= w_wr;
      if (w_clear) begin
        r_word_count <= '0;
      end else if (w_wr) begin
        r_word_count <= r_word_count + 1'b1;
      end
      if (w_wr) begin
        r_imem_addr  <= r_word_count[ADDR_WIDTH-1:0];
        r_imem_wdata <= s_in.in_data;
      end
    end
  end

  loader_checksum #(.DATA_WIDTH(DATA_WIDTH)) u_checksum (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_clear),
    .i_en    (w_wr),
    .i_data  (s_in.in_data),
    .i_cmp   (s_in.in_data),
    .o_sum   (w_sum),
    .o_match (w_match)
  );

  assign s_in.in_ready = w_ready;
  assign o_imem_we     = r_imem_we;
  assign o_imem_addr   = r_imem_addr;
  assign o_imem_wdata  = r_imem_wdata;
  assign o_core_reset  = (r_state != RUN);
  assign o_busy        = w_ready;
  assign o_done        = (r_state == RUN);
  assign o_error       = (r_state == ERR);
  assign o_word_count  = r_word_count;

endmodule
